// File: rtl/qe_signal_generator.sv
// qe_signal_generator: emits commanded quadrature edges on QE_A/QE_B/QE_I at a programmable rate.
//   clk, reset (async active-low)        clock and reset
//   enable                               1 = run, 0 = pause (timer and outputs frozen)
//   cmd_valid/cmd_ready                  command handshake (ready only in IDLE)
//   cmd_steps, cmd_dir, phase_time       edge count, direction (1 = CW), clocks-1 per edge
//   counts_per_rev                       edges per revolution (0 disables the index)
//   flip_AB, abort, pos_load, pos_value  A/B swap, stop request, position preset
//   QE_A, QE_B, QE_I                     registered quadrature and index outputs
//   busy, done, aborted, position        status and signed edge position
module qe_signal_generator #(
  parameter int CNT_W     = 32,
  parameter int MIN_PHASE = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] phase_time,
  input  logic [CNT_W-1:0] counts_per_rev,
  input  logic             flip_AB,
  input  logic             abort,
  input  logic             pos_load,
  input  logic [CNT_W-1:0] pos_value,
  output logic             QE_A,
  output logic             QE_B,
  output logic             QE_I,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] position
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;
  logic [1:0] idx, idx_nx;
  logic [CNT_W-1:0] rev, rev_nx, timer, steps_left, eff_pt, pt_clamp;
  logic dir, accept, fire, last, stop, a_nx, b_nx;
  assign pt_clamp = phase_time < CNT_W'(MIN_PHASE) ? CNT_W'(MIN_PHASE) : phase_time;
  assign accept   = state == IDLE && cmd_valid;
  assign fire     = state == RUN && enable && timer == '0;
  assign last     = steps_left == CNT_W'(1);
  // abort is honoured even while paused; a coinciding edge is still emitted
  assign stop     = state == RUN && (abort || (fire && last));
  assign idx_nx   = dir ? idx + 2'd1 : idx - 2'd1;
  // gray walk 0,1,2,3 -> AB 00,10,11,01
  assign a_nx     = idx_nx[0] ^ idx_nx[1];
  assign b_nx     = idx_nx[1];
  // compared against the live counts_per_rev, so an out-of-range count wraps on the next CW edge
  assign rev_nx   = counts_per_rev == '0 ? '0 :
                    dir ? (rev >= counts_per_rev - CNT_W'(1) ? '0 : rev + CNT_W'(1)) :
                    (rev == '0 ? counts_per_rev - CNT_W'(1) : rev - CNT_W'(1));
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx  = state;
    cmd_ready = state == IDLE;
    busy      = state == RUN;
    if (state == IDLE && accept && cmd_steps != '0) state_nx = RUN;
    if (stop) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      idx        <= '0;
      rev        <= '0;
      timer      <= '0;
      steps_left <= '0;
      eff_pt     <= '0;
      dir        <= 1'b0;
      QE_A       <= 1'b0;
      QE_B       <= 1'b0;
      QE_I       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      position   <= '0;
    end else begin
      done <= (accept && cmd_steps == '0) || stop;
      if (accept) begin
        steps_left <= cmd_steps;
        dir        <= cmd_dir;
        timer      <= pt_clamp;
        eff_pt     <= pt_clamp;
        aborted    <= 1'b0;
      end
      if (stop) aborted <= !(fire && last);
      if (state == RUN && enable && timer != '0) timer <= timer - CNT_W'(1);
      if (fire) begin
        idx        <= idx_nx;
        rev        <= rev_nx;
        QE_A       <= flip_AB ? b_nx : a_nx;
        QE_B       <= flip_AB ? a_nx : b_nx;
        QE_I       <= rev_nx == '0 && counts_per_rev != '0;
        steps_left <= steps_left - CNT_W'(1);
        timer      <= eff_pt;
      end
      if (pos_load && state == IDLE) position <= pos_value;
      else if (fire) position <= dir ? position + CNT_W'(1) : position - CNT_W'(1);
    end
endmodule

// File: tb/tb_qe_signal_generator.sv
// tb_qe_signal_generator: randomized and directed checks of qe_signal_generator against a behavioural model.
module tb_qe_signal_generator;
  logic clk = 0, reset = 0, enable = 0, cmd_valid = 0, cmd_dir = 0, flip_AB = 0, abort = 0, pos_load = 0;
  logic [31:0] cmd_steps = 0, phase_time = 0, counts_per_rev = 0, pos_value = 0;
  logic cmd_ready, QE_A, QE_B, QE_I, busy, done, aborted;
  logic [31:0] position;
  int total = 0, bad = 0;
  int m_idx;
  longint m_rev;
  logic [31:0] m_pos;
  logic m_a, m_b, m_i, m_ab;
  logic [1:0] tab [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

  qe_signal_generator dut (
    .clk(clk), .reset(reset), .enable(enable), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_steps(cmd_steps), .cmd_dir(cmd_dir), .phase_time(phase_time), .counts_per_rev(counts_per_rev),
    .flip_AB(flip_AB), .abort(abort), .pos_load(pos_load), .pos_value(pos_value),
    .QE_A(QE_A), .QE_B(QE_B), .QE_I(QE_I), .busy(busy), .done(done), .aborted(aborted), .position(position)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_idx = 0; m_rev = 0; m_pos = 0; m_a = 0; m_b = 0; m_i = 0; m_ab = 0;
  endtask

  task automatic model_edge(input bit dir, input bit flip);
    longint cpr;
    logic [1:0] ab;
    cpr = longint'(counts_per_rev);
    m_idx = (m_idx + (dir ? 1 : 3)) % 4;
    m_pos = dir ? m_pos + 1 : m_pos - 1;
    if (cpr == 0) m_rev = 0;
    else if (dir) m_rev = (m_rev + 1 >= cpr) ? 0 : m_rev + 1;
    else m_rev = (m_rev == 0) ? cpr - 1 : m_rev - 1;
    ab = tab[m_idx];
    m_a = flip ? ab[0] : ab[1];
    m_b = flip ? ab[1] : ab[0];
    m_i = cpr != 0 && m_rev == 0;
  endtask

  function automatic logic [38:0] ev(input bit b, input bit d, input bit r);
    return {m_a, m_b, m_i, b, d, m_ab, r, m_pos};
  endfunction

  function automatic logic [38:0] got();
    return {QE_A, QE_B, QE_I, busy, done, aborted, cmd_ready, position};
  endfunction

  task automatic do_reset();
    reset = 0;
    @(negedge clk);
    reset = 1;
    model_reset();
  endtask

  // Called at a negedge. Edges fall due on every (eff+1)-th enabled clock after the accept.
  task automatic do_cmd(input string nm, input int steps, input bit dir, input int pt, input bit flip,
                        input int abort_at, input int pause_at, input int pause_len, input bit rnd);
    int eff, a, k, n;
    bit en, ab, fin, edge_now, exp_done;
    logic [38:0] e;
    eff = pt < 2 ? 2 : pt;
    cmd_valid = 1; cmd_steps = steps; cmd_dir = dir; phase_time = pt; flip_AB = flip;
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL %s ready got=%b exp=1", nm, cmd_ready); end
    @(negedge clk);
    cmd_valid = 0; pos_load = 0; m_ab = 0;
    e = steps == 0 ? ev(0, 1, 1) : ev(1, 0, 0);
    total++;
    if (got() !== e) begin bad++; $display("FAIL %s accept got=%h exp=%h", nm, got(), e); end
    if (steps == 0) begin
      @(negedge clk);
      total++;
      if (got() !== ev(0, 0, 1)) begin bad++; $display("FAIL %s zero_after got=%h exp=%h", nm, got(), ev(0, 0, 1)); end
      return;
    end
    a = 0; k = 0; n = 0; fin = 0;
    while (!fin && n < 3000) begin
      n++;
      en = rnd ? ($urandom_range(0, 3) != 0) : !(n >= pause_at && n < pause_at + pause_len);
      ab = n == abort_at;
      enable = en; abort = ab;
      if (rnd) begin
        cmd_valid = $urandom_range(0, 1); cmd_steps = $urandom; cmd_dir = $urandom_range(0, 1);
        phase_time = $urandom_range(0, 5); pos_load = $urandom_range(0, 1); pos_value = $urandom;
      end
      @(negedge clk);
      edge_now = en && ((a + 1) % (eff + 1) == 0);
      if (en) a++;
      if (edge_now) begin model_edge(dir, flip); k++; end
      exp_done = ab || (edge_now && k == steps);
      if (exp_done) begin fin = 1; m_ab = k != steps; end
      e = ev(!fin, exp_done, fin);
      total++;
      if (got() !== e) begin bad++; $display("FAIL %s n=%0d got=%h exp=%h", nm, n, got(), e); end
    end
    enable = 1; abort = 0; cmd_valid = 0; pos_load = 0;
    if (!fin) begin total++; bad++; $display("FAIL %s timeout got=busy%b exp=done", nm, busy); end
    @(negedge clk);
    total++;
    if (got() !== ev(0, 0, 1)) begin bad++; $display("FAIL %s idle_after got=%h exp=%h", nm, got(), ev(0, 0, 1)); end
  endtask

  task automatic test_reset();
    reset = 0;
    repeat (3) @(negedge clk);
    reset = 1; enable = 1;
    model_reset();
    @(negedge clk);
    total++;
    if (got() !== {7'b0000001, 32'd0}) begin bad++; $display("FAIL reset got=%h exp=%h", got(), {7'b0000001, 32'd0}); end
  endtask

  task automatic test_cw();
    counts_per_rev = 0;
    do_cmd("cw8", 8, 1, 4, 0, 0, 0, 0, 0);
    total++;
    if ({QE_A, QE_B, QE_I, position} !== {3'b000, 32'd8}) begin bad++; $display("FAIL cw8_end got=%h exp=%h", {QE_A, QE_B, QE_I, position}, {3'b000, 32'd8}); end
  endtask

  task automatic test_reverse();
    do_cmd("ccw3", 3, 0, 4, 0, 0, 0, 0, 0);
    total++;
    if ({QE_A, QE_B, position} !== {2'b10, 32'd5}) begin bad++; $display("FAIL ccw3_end got=%h exp=%h", {QE_A, QE_B, position}, {2'b10, 32'd5}); end
  endtask

  task automatic test_zero_steps();
    do_cmd("zero", 0, 1, 4, 0, 0, 0, 0, 0);
  endtask

  task automatic test_pos_wrap();
    counts_per_rev = 4;
    pos_load = 1; pos_value = 32'hFFFF_FFFF; m_pos = 32'hFFFF_FFFF;
    do_cmd("poswrap", 2, 1, 3, 0, 0, 0, 0, 0);
    total++;
    if (position !== 32'd1) begin bad++; $display("FAIL poswrap_end got=%h exp=00000001", position); end
  endtask

  task automatic test_index();
    do_reset();
    counts_per_rev = 4;
    do_cmd("index_cw", 4, 1, 2, 0, 0, 0, 0, 0);
    total++;
    if (QE_I !== 1'b1) begin bad++; $display("FAIL index_high got=%b exp=1", QE_I); end
    do_cmd("index_ccw", 1, 0, 2, 0, 0, 0, 0, 0);
    total++;
    if (QE_I !== 1'b0) begin bad++; $display("FAIL index_low got=%b exp=0", QE_I); end
  endtask

  task automatic test_min_phase();
    for (int p = 0; p < 3; p++) do_cmd($sformatf("minpt%0d", p), 3, 1, p, 0, 0, 0, 0, 0);
  endtask

  task automatic test_flip();
    do_cmd("flip", 4, 1, 2, 1, 0, 0, 0, 0);
    flip_AB = 0;
  endtask

  task automatic test_abort();
    logic [31:0] p0;
    p0 = m_pos;
    do_cmd("abort_mid", 100, 1, 10, 0, 37, 0, 0, 0);
    total++;
    if (position !== p0 + 32'd3) begin bad++; $display("FAIL abort_pos got=%h exp=%h", position, p0 + 32'd3); end
    do_cmd("abort_last", 2, 1, 3, 0, 8, 0, 0, 0);
    do_cmd("abort_paused", 10, 0, 3, 0, 6, 5, 5, 0);
    abort = 1;
    @(negedge clk);
    abort = 0;
    total++;
    if (got() !== ev(0, 0, 1)) begin bad++; $display("FAIL abort_idle got=%h exp=%h", got(), ev(0, 0, 1)); end
  endtask

  task automatic test_pause();
    do_cmd("pause", 6, 1, 3, 0, 0, 6, 20, 0);
  endtask

  task automatic test_reset_midrun();
    cmd_valid = 1; cmd_steps = 10; cmd_dir = 1; phase_time = 3;
    @(negedge clk);
    cmd_valid = 0;
    repeat (9) @(negedge clk);
    #2 reset = 0;
    #1 model_reset();
    total++;
    if (got() !== ev(0, 0, 1)) begin bad++; $display("FAIL rst_async got=%h exp=%h", got(), ev(0, 0, 1)); end
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    total++;
    if (got() !== ev(0, 0, 1)) begin bad++; $display("FAIL rst_release got=%h exp=%h", got(), ev(0, 0, 1)); end
  endtask

  task automatic test_random();
    int s, p, ea, al;
    do_reset();
    counts_per_rev = 6;
    for (int i = 0; i < 25; i++) begin
      s = $urandom_range(0, 12);
      p = $urandom_range(0, 5);
      ea = (p < 2 ? 2 : p) + 1;
      al = $urandom_range(0, 1) ? $urandom_range(1, s * ea * 2 + 2) : 0;
      do_cmd($sformatf("rand%0d", i), s, $urandom_range(0, 1), p, $urandom_range(0, 1), al, 0, 0, 1);
    end
  endtask

  initial begin
    test_reset();
    test_cw();
    test_reverse();
    test_zero_steps();
    test_pos_wrap();
    test_index();
    test_min_phase();
    test_flip();
    test_abort();
    test_pause();
    test_reset_midrun();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
